phys_reg_free_list_ctrl: RTL and testbench
==========================================

# phys_reg_free_list_ctrl

Sequencing and arbitration controller for the physical-register free list FIFO in the renaming stage. After reset it fills the free list with every physical register ID not holding an initial architectural mapping. In run mode it then:
- serves rename-side allocations (pops) and allocation rollback;
- merges two retire-side release streams into the FIFO's single push port.

It tracks free-entry occupancy and sits between the rename/retire logic and the free list FIFO instance.

## Interface
Parameters:
- NUM_PHYS_REGS, 64, total physical registers; power of 2; FIFO depth = NUM_PHYS_REGS.
- NUM_ARCH_REGS, 32, architectural registers; IDs 0..NUM_ARCH_REGS-1 are mapped at reset and never preloaded.
- PHYS_ID_W, $clog2(NUM_PHYS_REGS), physical ID width.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
  - clk, in, 1, clock.
  - rst, in, 1, reset; synchronous, active-high.
- Rename side:
  - alloc_req, in, 1, rename requests one free physical ID.
  - alloc_ack, out, 1, allocation granted this cycle.
  - alloc_id, out, PHYS_ID_W, granted ID; valid when alloc_ack=1.
  - rollback, in, 1, undo the most recent acknowledged allocation.
- Retire side:
  - release_valid, in, 2, per-port release request.
  - release_id_0, in, PHYS_ID_W, ID freed by port 0.
  - release_id_1, in, PHYS_ID_W, ID freed by port 1.
  - release_ready, out, 2, per-port acceptance (one-hot or zero).
- Free list FIFO side:
  - fl_push, out, 1, push to free list.
  - fl_potential_push, out, 1, FIFO RAM write enable.
  - fl_data_in, out, PHYS_ID_W, push data.
  - fl_pop, out, 1, pop from free list.
  - fl_rollback, out, 1, FIFO read-pointer rollback.
  - fl_data_out, in, PHYS_ID_W, FIFO head.
  - fl_valid, in, 1, FIFO holds at least one entry.
  - fl_full, in, 1, FIFO full.
- Status:
  - init_done, out, 1, free list fully populated.
  - free_count, out, PHYS_ID_W+1, number of free IDs held.

## Operation
- FSM has two states, INIT and RUN.
  - Reset state is INIT.
  - INIT -> RUN after the last preload push.
  - There is no other transition; only rst returns to INIT.
- INIT:
  - Counter init_id starts at NUM_ARCH_REGS.
  - Each cycle: fl_push=fl_potential_push=1, fl_data_in=init_id, init_id+1.
  - The push with init_id=NUM_PHYS_REGS-1 is the last preload push.
  - alloc_ack=0, release_ready=0, fl_pop=0, fl_rollback=0.
  - rollback and release_valid are ignored.
- RUN, allocation:
  - alloc_ack = alloc_req & fl_valid & ~rollback.
  - fl_pop = alloc_ack; alloc_id = fl_data_out.
  - A cycle with rollback asserted never grants an allocation.
- RUN, rollback:
  - fl_rollback = rollback.
  - Legal only when the immediately preceding cycle had alloc_ack=1.
  - The rolled-back ID is re-presented on the next allocation.
- RUN, release arbitration:
  - Round-robin pointer rr: reset 0; 0 = port 0 has priority.
  - Candidate = the sole valid port, or port rr when both are valid.
  - Candidate is accepted when ~fl_full | fl_pop; release_ready[cand]=1, other bit 0.
  - After an accepted release from port i, rr <= ~i.
- RUN, push gating:
  - An accepted release with ID 0 is acknowledged but not pushed (physical 0 is permanently x0).
  - Otherwise fl_push=fl_potential_push=1, fl_data_in = accepted ID.
  - At most one push per cycle; a second valid port waits.
- free_count:
  - Reset 0.
  - Next value = free_count + fl_push - fl_pop + fl_rollback.
  - Width PHYS_ID_W+1; never exceeds NUM_PHYS_REGS under legal use.
- Boundaries:
  - Free list empty (fl_valid=0): alloc_ack=0, alloc_req holds.
  - Full with pop in the same cycle: the release is accepted (push/pop bypass).
  - Full without pop: release_ready=0.
  - Simultaneous alloc, release and rollback: rollback suppresses alloc; the release proceeds.
  - Reset mid-operation: FSM returns to INIT, init_id, rr and free_count reset, preload restarts.
  - The FIFO is reset by the same rst.

## Timing
- All FIFO-side outputs and alloc_ack/release_ready are combinational from current inputs and state.
- Zero-cycle acknowledge latency.
- State, init_id, rr, free_count and init_done are registered.
- Reset values: init_done=0, free_count=0, alloc_ack=0, release_ready=0.
  - fl_pop=0, fl_rollback=0, fl_push=0 while rst=1.
  - fl_data_in=NUM_ARCH_REGS.
- Preload timing:
  - Preload takes NUM_PHYS_REGS-NUM_ARCH_REGS cycles, starting with the first cycle rst=0.
  - init_done=1 from the following cycle; free_count equals NUM_PHYS_REGS-NUM_ARCH_REGS then.
- An allocated ID is visible at fl_data_out one cycle after its push (FIFO write latency).

## Test plan
- Reset release, defaults: pushes IDs 32..63 on cycles 0..31; init_done=1 on cycle 32; free_count=32; alloc/release ignored throughout.
- Allocate 32 back-to-back: IDs 32..63 in order. Then fl_valid=0 -> alloc_ack=0 and free_count=0.
- Alloc of 32 then rollback next cycle: alloc_ack=0 during rollback cycle; next alloc returns 32 again; free_count returns to 32.
- Both release ports valid for 4 cycles (IDs 5/6 constant): grants alternate 0,1,0,1; pushes 5,6,5,6. Port 0 alone then 1 alone: each granted immediately.
- Release of ID 0: release_ready=1, fl_push=0, free_count unchanged.
- FIFO full with release pending: release_ready=0. Same cycle plus alloc: release accepted, free_count unchanged. Assert rst mid-run: INIT restarts at ID 32, free_count=0.

Source files
------------

// File: rtl/phys_reg_free_list_ctrl.sv
// Free-list sequencing controller for the rename stage. It preloads the free physical IDs after
// reset, then serves rename allocations and rollback, and merges two retire release ports into a
// single push port.
module phys_reg_free_list_ctrl #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned PHYS_ID_W     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_ack,
  output logic [PHYS_ID_W-1:0] alloc_id,
  input  logic                 rollback,
  input  logic [1:0]           release_valid,
  input  logic [PHYS_ID_W-1:0] release_id_0,
  input  logic [PHYS_ID_W-1:0] release_id_1,
  output logic [1:0]           release_ready,
  output logic                 fl_push,
  output logic                 fl_potential_push,
  output logic [PHYS_ID_W-1:0] fl_data_in,
  output logic                 fl_pop,
  output logic                 fl_rollback,
  input  logic [PHYS_ID_W-1:0] fl_data_out,
  input  logic                 fl_valid,
  input  logic                 fl_full,
  output logic                 init_done,
  output logic [PHYS_ID_W:0]   free_count
);

  localparam int unsigned CNT_W = PHYS_ID_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [PHYS_ID_W-1:0] init_id_q, init_id_d;
  logic                 rr_q, rr_d;
  logic [CNT_W-1:0]     free_count_q, free_count_d;
  logic                 init_done_q, init_done_d;

  logic                 rel_cand;
  logic [PHYS_ID_W-1:0] rel_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_id_q    <= PHYS_ID_W'(NUM_ARCH_REGS);
      rr_q         <= 1'b0;
      free_count_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_id_q    <= init_id_d;
      rr_q         <= rr_d;
      free_count_q <= free_count_d;
      init_done_q  <= init_done_d;
    end
  end

  // Preload sequencing, allocation and release arbitration; every FIFO-side strobe is held low in reset.
  always_comb begin
    state_d           = state_q;
    init_id_d         = init_id_q;
    rr_d              = rr_q;
    init_done_d       = init_done_q;
    alloc_ack         = 1'b0;
    alloc_id          = fl_data_out;
    release_ready     = 2'b00;
    fl_push           = 1'b0;
    fl_potential_push = 1'b0;
    fl_data_in        = init_id_q;
    fl_pop            = 1'b0;
    fl_rollback       = 1'b0;

    rel_cand = (&release_valid) ? rr_q : release_valid[1];
    rel_id   = rel_cand ? release_id_1 : release_id_0;

    if (rst) begin
      fl_data_in = PHYS_ID_W'(NUM_ARCH_REGS);
    end else begin
      case (state_q)
        ST_INIT: begin
          fl_push           = 1'b1;
          fl_potential_push = 1'b1;
          init_id_d         = init_id_q + PHYS_ID_W'(1);
          if (init_id_q == PHYS_ID_W'(NUM_PHYS_REGS - 1)) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          alloc_ack   = alloc_req & fl_valid & ~rollback;
          fl_pop      = alloc_ack;
          fl_rollback = rollback;
          // A same-cycle pop frees the slot, so a full FIFO can still take the release.
          if ((|release_valid) && (!fl_full || alloc_ack)) begin
            release_ready[rel_cand] = 1'b1;
            rr_d                    = ~rel_cand;
            if (rel_id != '0) begin
              fl_push           = 1'b1;
              fl_potential_push = 1'b1;
              fl_data_in        = rel_id;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    free_count_d = free_count_q + CNT_W'(fl_push) - CNT_W'(fl_pop) + CNT_W'(fl_rollback);
  end

  assign init_done  = init_done_q;
  assign free_count = free_count_q;

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Directed bench for phys_reg_free_list_ctrl: the FIFO-side inputs are driven directly, and the
// outputs are compared against hand-computed values.
module tb_phys_reg_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req, alloc_ack, rollback;
  logic [5:0] alloc_id;
  logic [1:0] release_valid, release_ready;
  logic [5:0] release_id_0, release_id_1;
  logic       fl_push, fl_potential_push, fl_pop, fl_rollback;
  logic [5:0] fl_data_in, fl_data_out;
  logic       fl_valid, fl_full, init_done;
  logic [6:0] free_count;

  int errors = 0;
  int checks = 0;

  phys_reg_free_list_ctrl #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_id(alloc_id), .rollback(rollback),
    .release_valid(release_valid), .release_id_0(release_id_0), .release_id_1(release_id_1),
    .release_ready(release_ready),
    .fl_push(fl_push), .fl_potential_push(fl_potential_push), .fl_data_in(fl_data_in),
    .fl_pop(fl_pop), .fl_rollback(fl_rollback), .fl_data_out(fl_data_out),
    .fl_valid(fl_valid), .fl_full(fl_full),
    .init_done(init_done), .free_count(free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ar, rb;
    logic [1:0] rv;
    logic [5:0] id0, id1, dout;
    logic       fv, ff;
    logic       ack;
    logic [5:0] aid;
    logic [1:0] rdy;
    logic       push;
    logic [5:0] din;
    logic       pop, flrb;
    logic [6:0] fc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic ar, input logic rb, input logic [1:0] rv,
                              input logic [5:0] id0, input logic [5:0] id1, input logic [5:0] dout,
                              input logic fv, input logic ff, input logic ack, input logic [5:0] aid,
                              input logic [1:0] rdy, input logic push, input logic [5:0] din,
                              input logic pop, input logic flrb, input logic [6:0] fc);
    vec_t v;
    v.ar = ar; v.rb = rb; v.rv = rv; v.id0 = id0; v.id1 = id1; v.dout = dout;
    v.fv = fv; v.ff = ff; v.ack = ack; v.aid = aid; v.rdy = rdy; v.push = push;
    v.din = din; v.pop = pop; v.flrb = flrb; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic rb, input logic [1:0] rv, input logic [5:0] id0,
                       input logic [5:0] id1, input logic [5:0] dout, input logic fv, input logic ff);
    alloc_req = ar; rollback = rb; release_valid = rv; release_id_0 = id0;
    release_id_1 = id1; fl_data_out = dout; fl_valid = fv; fl_full = ff;
  endtask

  // Preload with noisy rename/retire inputs that must all be ignored.
  task automatic run_preload();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 2'b11, 6'd7, 6'd8, 6'd9, 1'b1, 1'b0);
      #1;
      chk("pre_push", 32'(fl_push), 32'd1);
      chk("pre_ppush", 32'(fl_potential_push), 32'd1);
      chk("pre_din", 32'(fl_data_in), 32'(32 + i));
      chk("pre_ack", 32'(alloc_ack), 32'd0);
      chk("pre_rdy", 32'(release_ready), 32'd0);
      chk("pre_pop_rb", 32'({fl_pop, fl_rollback}), 32'd0);
      chk("pre_cnt", 32'(free_count), 32'(i));
      chk("pre_done", 32'(init_done), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'b00, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    #1;
    chk("post_done", 32'(init_done), 32'd1);
    chk("post_cnt", 32'(free_count), 32'd32);
    chk("post_push", 32'(fl_push), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    //           ar rb rv     id0 id1 dout fv ff ack aid rdy   push din pop rb fc
    vecs[0]  = mk(0, 0, 2'd3,  5,  6,  0,  0, 0, 0,  0, 2'd1, 1,   5,  0,  0, 0);
    vecs[1]  = mk(0, 0, 2'd3,  5,  6,  0,  0, 0, 0,  0, 2'd2, 1,   6,  0,  0, 1);
    vecs[2]  = mk(0, 0, 2'd3,  5,  6,  0,  0, 0, 0,  0, 2'd1, 1,   5,  0,  0, 2);
    vecs[3]  = mk(0, 0, 2'd3,  5,  6,  0,  0, 0, 0,  0, 2'd2, 1,   6,  0,  0, 3);
    vecs[4]  = mk(0, 0, 2'd1,  7,  0,  0,  0, 0, 0,  0, 2'd1, 1,   7,  0,  0, 4);
    vecs[5]  = mk(0, 0, 2'd2,  0,  9,  0,  0, 0, 0,  0, 2'd2, 1,   9,  0,  0, 5);
    vecs[6]  = mk(0, 0, 2'd1,  0,  0,  0,  0, 0, 0,  0, 2'd1, 0,   0,  0,  0, 6);
    vecs[7]  = mk(1, 0, 2'd0,  0,  0, 40,  1, 0, 1, 40, 2'd0, 0,   0,  1,  0, 6);
    vecs[8]  = mk(1, 1, 2'd0,  0,  0, 41,  1, 0, 0,  0, 2'd0, 0,   0,  0,  1, 5);
    vecs[9]  = mk(1, 0, 2'd0,  0,  0, 40,  1, 0, 1, 40, 2'd0, 0,   0,  1,  0, 6);
    vecs[10] = mk(0, 0, 2'd1, 12,  0, 41,  1, 1, 0,  0, 2'd0, 0,   0,  0,  0, 5);
    vecs[11] = mk(1, 0, 2'd1, 12,  0, 41,  1, 1, 1, 41, 2'd1, 1,  12,  1,  0, 5);
    vecs[12] = mk(1, 1, 2'd3, 13, 14, 42,  1, 0, 0,  0, 2'd2, 1,  14,  0,  1, 5);
    vecs[13] = mk(1, 0, 2'd0,  0,  0,  0,  0, 0, 0,  0, 2'd0, 0,   0,  0,  0, 7);
    vecs[14] = mk(0, 0, 2'd2,  0,  3,  0,  1, 1, 0,  0, 2'd0, 0,   0,  0,  0, 7);
    vecs[15] = mk(0, 0, 2'd1, 15,  0,  0,  0, 0, 0,  0, 2'd1, 1,  15,  0,  0, 7);

    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 6'd5, 6'd6, 6'd40, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_push", 32'(fl_push), 32'd0);
    chk("rst_din", 32'(fl_data_in), 32'd32);
    chk("rst_ack", 32'(alloc_ack), 32'd0);
    chk("rst_rdy", 32'(release_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_cnt", 32'(free_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_preload();

    // Drain all 32 preloaded IDs back to back.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 2'b00, 6'd0, 6'd0, 6'(32 + i), 1'b1, 1'b0);
      #1;
      chk("drain_ack", 32'(alloc_ack), 32'd1);
      chk("drain_id", 32'(alloc_id), 32'(32 + i));
      chk("drain_pop", 32'(fl_pop), 32'd1);
      chk("drain_cnt", 32'(free_count), 32'(32 - i));
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 2'b00, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    #1;
    chk("empty_ack", 32'(alloc_ack), 32'd0);
    chk("empty_pop", 32'(fl_pop), 32'd0);
    chk("empty_cnt", 32'(free_count), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].ar, vecs[k].rb, vecs[k].rv, vecs[k].id0, vecs[k].id1, vecs[k].dout,
            vecs[k].fv, vecs[k].ff);
      #1;
      chk($sformatf("v%0d_ack", k), 32'(alloc_ack), 32'(vecs[k].ack));
      if (vecs[k].ack) chk($sformatf("v%0d_aid", k), 32'(alloc_id), 32'(vecs[k].aid));
      chk($sformatf("v%0d_rdy", k), 32'(release_ready), 32'(vecs[k].rdy));
      chk($sformatf("v%0d_push", k), 32'({fl_push, fl_potential_push}), 32'({vecs[k].push, vecs[k].push}));
      if (vecs[k].push) chk($sformatf("v%0d_din", k), 32'(fl_data_in), 32'(vecs[k].din));
      chk($sformatf("v%0d_pop", k), 32'(fl_pop), 32'(vecs[k].pop));
      chk($sformatf("v%0d_flrb", k), 32'(fl_rollback), 32'(vecs[k].flrb));
      chk($sformatf("v%0d_cnt", k), 32'(free_count), 32'(vecs[k].fc));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'b00, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    #1;
    chk("tab_end_cnt", 32'(free_count), 32'd8);

    // Mid-run reset with rr pointing at port 1; everything must restart from scratch.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b11, 6'd5, 6'd6, 6'd40, 1'b1, 1'b0);
    #1;
    chk("mrst_push", 32'(fl_push), 32'd0);
    chk("mrst_pop_rb", 32'({fl_pop, fl_rollback}), 32'd0);
    chk("mrst_din", 32'(fl_data_in), 32'd32);
    @(negedge clk);
    #1;
    chk("mrst_cnt", 32'(free_count), 32'd0);
    chk("mrst_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_preload();
    drive(1'b0, 1'b0, 2'b11, 6'd5, 6'd6, 6'd0, 1'b0, 1'b0);
    #1;
    chk("mrst_rr", 32'(release_ready), 32'd1);
    chk("mrst_rr_din", 32'(fl_data_in), 32'd5);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
